// File: rtl/pipeline_fifo_buffer_monitored.sv
// Ready/valid FIFO with a registered output word, optional circular overwrite,
// registered fill-level/almost flags, synchronous flush and a saturating drop counter.
module pipeline_fifo_buffer_monitored #(
    parameter int    WORD_WIDTH         = 8,
    parameter int    DEPTH              = 5,
    parameter string RAMSTYLE           = "",
    parameter int    CIRCULAR_BUFFER    = 0,
    parameter int    ALMOST_FULL_LEVEL  = DEPTH,
    parameter int    ALMOST_EMPTY_LEVEL = 1,
    parameter int    DROP_COUNT_WIDTH   = 16,
    localparam int   FILL_WIDTH         = $clog2(DEPTH + 2)
) (
    input  logic                        clock,
    input  logic                        clear_n,
    input  logic                        flush,
    input  logic                        input_valid,
    output logic                        input_ready,
    input  logic [WORD_WIDTH-1:0]       input_data,
    output logic                        output_valid,
    input  logic                        output_ready,
    output logic [WORD_WIDTH-1:0]       output_data,
    output logic [FILL_WIDTH-1:0]       fill_level,
    output logic                        almost_full,
    output logic                        almost_empty,
    output logic [DROP_COUNT_WIDTH-1:0] dropped_count
);

    localparam int                    ADDR_WIDTH = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR  = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [31:0]           AF_LEVEL   = ALMOST_FULL_LEVEL;
    localparam logic [31:0]           AE_LEVEL   = ALMOST_EMPTY_LEVEL;
    localparam bit                    CIRCULAR   = (CIRCULAR_BUFFER != 0);

    (* ramstyle = RAMSTYLE *)
    logic [WORD_WIDTH-1:0] mem [DEPTH];

    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  wr_wrap;
    logic                  rd_wrap;
    logic                  mem_full;
    logic                  mem_empty;
    logic                  insert;
    logic                  remove_normal;
    logic                  remove_circular;
    logic                  drop;
    logic                  load;
    logic                  read_en;
    logic [FILL_WIDTH-1:0] fill_next;

    always_comb begin
        mem_full        = (wr_addr == rd_addr) && (wr_wrap != rd_wrap);
        mem_empty       = (wr_addr == rd_addr) && (wr_wrap == rd_wrap);
        input_ready     = (!mem_full || CIRCULAR) && !flush;
        insert          = input_valid && input_ready;
        remove_normal   = output_valid && output_ready;
        remove_circular = CIRCULAR && mem_full && insert;
        // an overwritten word that was on display and not taken is a loss
        drop            = remove_circular && output_valid && !output_ready;
        load            = remove_normal || remove_circular || (!output_valid && !mem_empty);
        read_en         = load && !mem_empty && !flush;
        fill_next       = fill_level + FILL_WIDTH'(insert)
                          - FILL_WIDTH'(remove_normal) - FILL_WIDTH'(drop);
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            wr_addr <= '0;
            rd_addr <= '0;
            wr_wrap <= 1'b0;
            rd_wrap <= 1'b0;
        end else if (flush) begin
            wr_addr <= '0;
            rd_addr <= '0;
            wr_wrap <= 1'b0;
            rd_wrap <= 1'b0;
        end else begin
            if (insert) begin
                if (wr_addr == LAST_ADDR) begin
                    wr_addr <= '0;
                    wr_wrap <= ~wr_wrap;
                end else begin
                    wr_addr <= wr_addr + 1'b1;
                end
            end
            if (read_en) begin
                if (rd_addr == LAST_ADDR) begin
                    rd_addr <= '0;
                    rd_wrap <= ~rd_wrap;
                end else begin
                    rd_addr <= rd_addr + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            output_valid  <= 1'b0;
            fill_level    <= '0;
            almost_full   <= 1'b0;
            almost_empty  <= 1'b1;
            dropped_count <= '0;
        end else if (flush) begin
            output_valid <= 1'b0;
            fill_level   <= '0;
            almost_full  <= (AF_LEVEL == 32'd0);
            almost_empty <= 1'b1;
        end else begin
            if (load) begin
                output_valid <= !mem_empty;
            end
            fill_level   <= fill_next;
            almost_full  <= (32'(fill_next) >= AF_LEVEL);
            almost_empty <= (32'(fill_next) <= AE_LEVEL);
            if (drop && !(&dropped_count)) begin
                dropped_count <= dropped_count + 1'b1;
            end
        end
    end

    // read-before-write: a circular overwrite of the slot being read still yields the old word
    always_ff @(posedge clock) begin
        if (insert) begin
            mem[wr_addr] <= input_data;
        end
        if (read_en) begin
            output_data <= mem[rd_addr];
        end
    end

endmodule

// File: tb/tb_pipeline_fifo_buffer_monitored.sv
// Bench for pipeline_fifo_buffer_monitored: a normal-mode and a circular-mode instance
// checked against a timestamped queue model, a fixed vector table and directed sequences.
module tb_pipeline_fifo_buffer_monitored;

    localparam int DEPTH = 5;

    logic clock = 1'b0;
    logic clear_n = 1'b0;
    always #5 clock = ~clock;

    logic       in_v [2];
    logic [7:0] in_d [2];
    logic       in_r [2];
    logic       in_f [2];

    logic        n_ir, n_ov, n_af, n_ae;
    logic [7:0]  n_od;
    logic [2:0]  n_fill;
    logic [15:0] n_drc;
    logic        c_ir, c_ov, c_af, c_ae;
    logic [7:0]  c_od;
    logic [2:0]  c_fill;
    logic [15:0] c_drc;

    pipeline_fifo_buffer_monitored #(.WORD_WIDTH(8), .DEPTH(DEPTH), .CIRCULAR_BUFFER(0)) dut_norm (
        .clock(clock), .clear_n(clear_n), .flush(in_f[0]),
        .input_valid(in_v[0]), .input_ready(n_ir), .input_data(in_d[0]),
        .output_valid(n_ov), .output_ready(in_r[0]), .output_data(n_od),
        .fill_level(n_fill), .almost_full(n_af), .almost_empty(n_ae), .dropped_count(n_drc)
    );

    pipeline_fifo_buffer_monitored #(.WORD_WIDTH(8), .DEPTH(DEPTH), .CIRCULAR_BUFFER(1)) dut_circ (
        .clock(clock), .clear_n(clear_n), .flush(in_f[1]),
        .input_valid(in_v[1]), .input_ready(c_ir), .input_data(in_d[1]),
        .output_valid(c_ov), .output_ready(in_r[1]), .output_data(c_od),
        .fill_level(c_fill), .almost_full(c_af), .almost_empty(c_ae), .dropped_count(c_drc)
    );

    typedef struct packed {
        logic ir; logic ov; logic [7:0] od; logic [2:0] fill; logic af; logic ae; logic [15:0] drc;
    } obs_t;

    typedef struct packed {
        logic iv; logic [7:0] id; logic rdy;
        logic ov; logic [7:0] od; logic [2:0] fill; logic af; logic ae; logic ir;
    } vec_t;

    int checks = 0;
    int errors = 0;

    // model: per instance, an ordered list of held words with the cycle each was accepted
    logic [7:0] m_data [2][8];
    int         m_tins [2][8];
    int         m_head [2];
    int         m_cnt  [2];
    int         m_drops[2];
    int         cyc = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic obs_t obs(int k);
        obs_t o;
        if (k == 0) o = '{n_ir, n_ov, n_od, n_fill, n_af, n_ae, n_drc};
        else        o = '{c_ir, c_ov, c_od, c_fill, c_af, c_ae, c_drc};
        return o;
    endfunction

    // a held word is presented once two cycles have passed since it was accepted
    function automatic bit m_vis(int k);
        return (m_cnt[k] > 0) && (m_tins[k][m_head[k]] + 2 <= cyc);
    endfunction

    function automatic int m_mem(int k);
        return m_cnt[k] - (m_vis(k) ? 1 : 0);
    endfunction

    function automatic bit m_ready(int k, logic f);
        return !f && ((k == 1) || (m_mem(k) < DEPTH));
    endfunction

    task automatic m_reset();
        for (int k = 0; k < 2; k++) begin
            m_head[k] = 0; m_cnt[k] = 0; m_drops[k] = 0;
        end
    endtask

    task automatic m_step(input int k);
        bit vis, full, ins;
        int idx;
        vis  = m_vis(k);
        full = (m_mem(k) == DEPTH);
        ins  = in_v[k] && m_ready(k, in_f[k]);
        if (in_f[k]) begin
            m_head[k] = 0; m_cnt[k] = 0;
            return;
        end
        if (vis && (in_r[k] || ((k == 1) && full && ins))) begin
            if (!in_r[k] && m_drops[k] < 65535) m_drops[k]++;
            m_head[k] = (m_head[k] + 1) % 8;
            m_cnt[k]--;
        end
        if (ins) begin
            idx = (m_head[k] + m_cnt[k]) % 8;
            m_data[k][idx] = in_d[k];
            m_tins[k][idx] = cyc;
            m_cnt[k]++;
        end
    endtask

    task automatic sample_and_check();
        obs_t  o;
        string p;
        @(negedge clock);
        for (int k = 0; k < 2; k++) begin
            o = obs(k);
            p = (k == 0) ? "norm" : "circ";
            chk({p, " output_valid"}, o.ov, m_vis(k));
            if (m_vis(k)) chk({p, " output_data"}, o.od, m_data[k][m_head[k]]);
            chk({p, " fill_level"}, o.fill, m_cnt[k]);
            chk({p, " almost_full"}, o.af, (m_cnt[k] >= DEPTH) ? 1 : 0);
            chk({p, " almost_empty"}, o.ae, (m_cnt[k] <= 1) ? 1 : 0);
            chk({p, " input_ready"}, o.ir, m_ready(k, in_f[k]));
            chk({p, " dropped_count"}, o.drc, m_drops[k]);
        end
    endtask

    task automatic advance();
        @(posedge clock);
        for (int k = 0; k < 2; k++) m_step(k);
        cyc++;
        #1;
    endtask

    task automatic cycle();
        sample_and_check();
        advance();
    endtask

    task automatic idle_inputs();
        for (int k = 0; k < 2; k++) begin
            in_v[k] = 1'b0; in_d[k] = 8'h00; in_r[k] = 1'b0; in_f[k] = 1'b0;
        end
    endtask

    function automatic vec_t mk(logic iv, logic [7:0] id, logic rdy, logic ov, logic [7:0] od,
                                int fill, logic af, logic ae, logic ir);
        vec_t v;
        v = '{iv, id, rdy, ov, od, 3'(fill), af, ae, ir};
        return v;
    endfunction

    vec_t       tbl [17];
    logic [7:0] got [32];
    logic [7:0] drain_exp [6];
    int         ndel, bubbles, maxfill;
    obs_t       o;

    initial begin
        // single insert latency, then fill to capacity and drain (normal instance)
        tbl[0]  = mk(1, 8'h11, 0, 0, 8'h00, 0, 0, 1, 1);
        tbl[1]  = mk(0, 8'h00, 0, 0, 8'h00, 1, 0, 1, 1);
        tbl[2]  = mk(0, 8'h00, 1, 1, 8'h11, 1, 0, 1, 1);
        tbl[3]  = mk(1, 8'h01, 0, 0, 8'h00, 0, 0, 1, 1);
        tbl[4]  = mk(1, 8'h02, 0, 0, 8'h00, 1, 0, 1, 1);
        tbl[5]  = mk(1, 8'h03, 0, 1, 8'h01, 2, 0, 0, 1);
        tbl[6]  = mk(1, 8'h04, 0, 1, 8'h01, 3, 0, 0, 1);
        tbl[7]  = mk(1, 8'h05, 0, 1, 8'h01, 4, 0, 0, 1);
        tbl[8]  = mk(1, 8'h06, 0, 1, 8'h01, 5, 1, 0, 1);
        tbl[9]  = mk(1, 8'h07, 0, 1, 8'h01, 6, 1, 0, 0);
        tbl[10] = mk(0, 8'h00, 1, 1, 8'h01, 6, 1, 0, 0);
        tbl[11] = mk(0, 8'h00, 1, 1, 8'h02, 5, 1, 0, 1);
        tbl[12] = mk(0, 8'h00, 1, 1, 8'h03, 4, 0, 0, 1);
        tbl[13] = mk(0, 8'h00, 1, 1, 8'h04, 3, 0, 0, 1);
        tbl[14] = mk(0, 8'h00, 1, 1, 8'h05, 2, 0, 0, 1);
        tbl[15] = mk(0, 8'h00, 1, 1, 8'h06, 1, 0, 1, 1);
        tbl[16] = mk(0, 8'h00, 0, 0, 8'h00, 0, 0, 1, 1);
        drain_exp[0] = 8'h05; drain_exp[1] = 8'h06; drain_exp[2] = 8'h07;
        drain_exp[3] = 8'h08; drain_exp[4] = 8'h09; drain_exp[5] = 8'hAA;

        idle_inputs();
        m_reset();
        clear_n = 1'b0;
        repeat (2) @(posedge clock);
        sample_and_check();
        clear_n = 1'b1;
        advance();

        for (int i = 0; i < 17; i++) begin
            in_v[0] = tbl[i].iv; in_d[0] = tbl[i].id; in_r[0] = tbl[i].rdy;
            sample_and_check();
            chk($sformatf("tbl%0d output_valid", i), n_ov, tbl[i].ov);
            if (tbl[i].ov) chk($sformatf("tbl%0d output_data", i), n_od, tbl[i].od);
            chk($sformatf("tbl%0d fill_level", i), n_fill, tbl[i].fill);
            chk($sformatf("tbl%0d almost_full", i), n_af, tbl[i].af);
            chk($sformatf("tbl%0d almost_empty", i), n_ae, tbl[i].ae);
            chk($sformatf("tbl%0d input_ready", i), n_ir, tbl[i].ir);
            advance();
        end
        idle_inputs();

        // 23-word stream through the normal instance
        ndel = 0; bubbles = 0; maxfill = 0;
        in_r[0] = 1'b1;
        for (int i = 0; i < 30; i++) begin
            in_v[0] = (i < 23);
            in_d[0] = 8'(i + 1);
            if (n_ov && ndel < 32) begin
                got[ndel] = n_od;
                ndel++;
            end else if (ndel > 0 && ndel < 23) begin
                bubbles++;
            end
            if (int'(n_fill) > maxfill) maxfill = int'(n_fill);
            cycle();
        end
        chk("stream delivered", ndel, 23);
        chk("stream bubbles", bubbles, 0);
        chk("stream max fill", maxfill, 2);
        for (int j = 0; j < 23; j++) chk($sformatf("stream word %0d", j), got[j], j + 1);
        idle_inputs();

        // circular overflow: nine words, consumer stalled
        for (int i = 0; i < 9; i++) begin
            in_v[1] = 1'b1; in_d[1] = 8'(i + 1);
            chk("circ ready during overflow", c_ir, 1);
            cycle();
        end
        in_v[1] = 1'b0;
        cycle();
        cycle();
        chk("circ overflow dropped", c_drc, 3);
        chk("circ overflow fill", c_fill, 6);
        chk("circ overflow head", c_od, 8'h04);

        // full circular buffer: insert and read in the same cycle is not a drop
        in_v[1] = 1'b1; in_d[1] = 8'hAA; in_r[1] = 1'b1;
        chk("circ simul read word", c_od, 8'h04);
        cycle();
        in_v[1] = 1'b0; in_r[1] = 1'b0;
        chk("circ simul dropped", c_drc, 3);
        chk("circ simul fill", c_fill, 6);
        in_r[1] = 1'b1;
        for (int j = 0; j < 6; j++) begin
            chk($sformatf("circ drain valid %0d", j), c_ov, 1);
            chk($sformatf("circ drain word %0d", j), c_od, drain_exp[j]);
            cycle();
        end
        chk("circ drained valid", c_ov, 0);
        chk("circ drained fill", c_fill, 0);
        idle_inputs();

        // flush with stored data
        for (int i = 0; i < 4; i++) begin
            in_v[0] = 1'b1; in_d[0] = 8'hB0 + 8'(i);
            in_v[1] = (i < 2); in_d[1] = 8'hC0 + 8'(i);
            cycle();
        end
        idle_inputs();
        cycle();
        chk("pre-flush fill", n_fill, 4);
        in_f[0] = 1'b1; in_f[1] = 1'b1;
        cycle();
        in_f[0] = 1'b0; in_f[1] = 1'b0;
        chk("flush output_valid", n_ov, 0);
        chk("flush fill", n_fill, 0);
        chk("flush almost_empty", n_ae, 1);
        chk("flush circ fill", c_fill, 0);
        chk("flush keeps dropped", c_drc, 3);
        in_v[0] = 1'b1; in_d[0] = 8'h5C;
        cycle();
        in_v[0] = 1'b0;
        repeat (3) cycle();

        // randomized traffic on both instances
        for (int i = 0; i < 800; i++) begin
            for (int k = 0; k < 2; k++) begin
                in_v[k] = ($urandom_range(0, 3) != 0);
                in_d[k] = 8'($urandom);
                in_r[k] = (i < 400) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 2) != 0);
                in_f[k] = ($urandom_range(0, 59) == 0);
            end
            cycle();
        end
        idle_inputs();

        // asynchronous reset in the middle of a clock period with data held
        for (int i = 0; i < 8; i++) begin
            in_v[0] = 1'b1; in_d[0] = 8'(i + 8'h40);
            in_v[1] = 1'b1; in_d[1] = 8'(i + 8'h60);
            cycle();
        end
        idle_inputs();
        #2 clear_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            o = obs(k);
            chk($sformatf("async reset output_valid %0d", k), o.ov, 0);
            chk($sformatf("async reset fill %0d", k), o.fill, 0);
            chk($sformatf("async reset almost_full %0d", k), o.af, 0);
            chk($sformatf("async reset almost_empty %0d", k), o.ae, 1);
            chk($sformatf("async reset dropped %0d", k), o.drc, 0);
            chk($sformatf("async reset input_ready %0d", k), o.ir, 1);
        end
        m_reset();
        @(negedge clock);
        clear_n = 1'b1;
        @(posedge clock);
        cyc++;
        #1;
        in_v[0] = 1'b1; in_d[0] = 8'h5A; in_v[1] = 1'b1; in_d[1] = 8'hA5;
        cycle();
        idle_inputs();
        repeat (3) cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
